// File: rtl/tape_rec.sv
// Cassette capture decoder: measures tape pulse widths, pairs cycles into bits,
// frames bytes and writes them to the tape buffer RAM. Optional checksum: TAPE_REC_CHECKSUM_EN.
module tape_rec #(
    parameter int SHORT_MAX = 1,
    parameter int LONG_MAX  = 3,
    parameter int TIMEOUT   = 64,
    parameter int CW        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_tape,
    input  logic        tape_in,
    input  logic        arm,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  checksum
);

    typedef enum logic [1:0] {IDLE, HUNT, DATA, STOP} state_e;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          sync1_q, sync2_q, sync3_q;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] gap_q, gap_d;
    state_e        state_q, state_d;
    logic          half_q, half_d;
    logic          first_long_q, first_long_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    stop_cnt_q, stop_cnt_d;
    logic          wr_q, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [15:0]   length_q, length_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic rise, fall, is_short, is_long, timeout_hit;

    // NOTE: every flop uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= tape_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;

    // A tick coinciding with the rising edge belongs to the new pulse.
    always_comb begin
        width_d = width_q;
        gap_d   = gap_q;
        if (rise) begin
            width_d = ce_tape ? CW'(1) : '0;
            gap_d   = ce_tape ? CW'(1) : '0;
        end else if (ce_tape) begin
            if (sync2_q && width_q != CNT_MAX) width_d = width_q + CW'(1);
            if (gap_q != CNT_MAX)              gap_d   = gap_q + CW'(1);
        end
    end

    assign is_short    = (width_q >= CW'(1)) && (width_q <= CW'(SHORT_MAX));
    assign is_long     = (width_q > CW'(SHORT_MAX)) && (width_q <= CW'(LONG_MAX));
    assign timeout_hit = (state_q != IDLE) && (gap_q == CW'(TIMEOUT)) && (length_q != 16'd0);

`ifdef TAPE_REC_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;
`endif

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        first_long_d = first_long_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        length_d     = length_q;
        done_d       = 1'b0;
        err_d        = err_q;
`ifdef TAPE_REC_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        if (arm) begin
            addr_d   = 16'd0;
            length_d = 16'd0;
            err_d    = 1'b0;
            half_d   = 1'b0;
            state_d  = HUNT;
`ifdef TAPE_REC_CHECKSUM_EN
            checksum_d = 8'h00;
`endif
        end else if (timeout_hit) begin
            if (state_q != HUNT) err_d = 1'b1;
            half_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (state_q != IDLE && fall) begin
            if (!is_short && !is_long) begin
                err_d   = 1'b1;
                half_d  = 1'b0;
                shift_d = 8'h00;
                state_d = HUNT;
            end else if (!half_q) begin
                half_d       = 1'b1;
                first_long_d = is_long;
            end else if (first_long_q != is_long) begin
                err_d   = 1'b1;
                half_d  = 1'b0;
                shift_d = 8'h00;
                state_d = HUNT;
            end else begin
                // Matched pair: two shorts encode 1, two longs encode 0.
                half_d = 1'b0;
                case (state_q)
                    HUNT: begin
                        if (is_long) begin
                            state_d   = DATA;
                            bit_cnt_d = 4'd8;
                        end
                    end
                    DATA: begin
                        shift_d   = {shift_q[6:0], is_short};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        if (bit_cnt_q == 4'd1) begin
                            state_d    = STOP;
                            stop_cnt_d = 2'd2;
                        end
                    end
                    STOP: begin
                        if (is_long) begin
                            err_d   = 1'b1;
                            shift_d = 8'h00;
                            state_d = HUNT;
                        end else if (stop_cnt_q == 2'd1) begin
                            wr_d   = 1'b1;
                            data_d = shift_q;
                            addr_d = length_q;
`ifdef TAPE_REC_CHECKSUM_EN
                            checksum_d = checksum_q + shift_q;
`endif
                            if (length_q == 16'hFFFF) begin
                                err_d   = 1'b1;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                length_d = length_q + 16'd1;
                                state_d  = HUNT;
                            end
                        end else begin
                            stop_cnt_d = stop_cnt_q - 2'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            width_q      <= '0;
            gap_q        <= '0;
            state_q      <= IDLE;
            half_q       <= 1'b0;
            first_long_q <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 4'd0;
            stop_cnt_q   <= 2'd0;
            wr_q         <= 1'b0;
            addr_q       <= 16'd0;
            data_q       <= 8'h00;
            length_q     <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            width_q      <= width_d;
            gap_q        <= gap_d;
            state_q      <= state_d;
            half_q       <= half_d;
            first_long_q <= first_long_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            length_q     <= length_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef TAPE_REC_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) checksum_q <= 8'h00;
        else       checksum_q <= checksum_d;
    end
    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign wr     = wr_q;
    assign addr   = addr_q;
    assign data   = data_q;
    assign length = length_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_tape_rec.sv
// Directed bench for tape_rec: drives player-timed frames (ce_tape every 4 clk)
// and checks the logged RAM writes and status outputs against hand-computed values.
module tb_tape_rec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_tape = 1'b0;
    logic        tape_in = 1'b0;
    logic        arm = 1'b0;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  checksum;

    int checks = 0;
    int failures = 0;

    int         wr_count = 0;
    int         done_count = 0;
    int         consec_wr = 0;
    logic       wr_prev = 1'b0;
    logic [15:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];

    tape_rec dut (
        .clk      (clk),
        .reset    (reset),
        .ce_tape  (ce_tape),
        .tape_in  (tape_in),
        .arm      (arm),
        .wr       (wr),
        .addr     (addr),
        .data     (data),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) begin
                @(negedge clk);
                ce_tape = 1'b0;
            end
            @(negedge clk);
            ce_tape = 1'b1;
        end
    end

    // Write/done log sampled on the falling edge.
    always @(negedge clk) begin
        if (wr) begin
            if (wr_count < 64) begin
                log_addr[wr_count] = addr;
                log_data[wr_count] = data;
            end
            wr_count = wr_count + 1;
        end
        if (wr && wr_prev) consec_wr = consec_wr + 1;
        wr_prev = wr;
        if (done) done_count = done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int ticks);
        repeat (4 * ticks) @(negedge clk);
    endtask

    task automatic send_cycle(input int hi, input int lo);
        tape_in = 1'b1;
        hold(hi);
        tape_in = 1'b0;
        hold(lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            send_cycle(1, 1);
            send_cycle(1, 1);
        end else begin
            send_cycle(2, 2);
            send_cycle(2, 2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic arm_capture();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic leader();
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    int          wr_base;
    int          done_base;
    logic [7:0]  exp_ck;

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_length", 32'(length), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);

        // Single frame A5
        wr_base = wr_count; done_base = done_count;
        arm_capture();
        @(negedge clk);
        check("t1_busy_armed", 32'(busy), 32'd1);
        leader();
        send_byte(8'hA5);
        hold(70);
        check("t1_wr_cnt", 32'(wr_count - wr_base), 32'd1);
        check("t1_addr", 32'(log_addr[wr_base]), 32'd0);
        check("t1_data", 32'(log_data[wr_base]), 32'hA5);
        check("t1_length", 32'(length), 32'd1);
        check("t1_done_cnt", 32'(done_count - done_base), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);
`ifdef TAPE_REC_CHECKSUM_EN
        exp_ck = 8'hA5;
`else
        exp_ck = 8'h00;
`endif
        check("t1_checksum", 32'(checksum), 32'(exp_ck));

        // Back-to-back frames
        wr_base = wr_count;
        arm_capture();
        leader();
        send_byte(8'h3C);
        send_byte(8'hC3);
        send_byte(8'h00);
        hold(70);
        check("t2_wr_cnt", 32'(wr_count - wr_base), 32'd3);
        check("t2_addr0", 32'(log_addr[wr_base]), 32'd0);
        check("t2_data0", 32'(log_data[wr_base]), 32'h3C);
        check("t2_addr1", 32'(log_addr[wr_base + 1]), 32'd1);
        check("t2_data1", 32'(log_data[wr_base + 1]), 32'hC3);
        check("t2_addr2", 32'(log_addr[wr_base + 2]), 32'd2);
        check("t2_data2", 32'(log_data[wr_base + 2]), 32'h00);
        check("t2_length", 32'(length), 32'd3);
        check("t2_err", 32'(err), 32'd0);

        // Mixed pair inside DATA, then valid 55
        wr_base = wr_count;
        arm_capture();
        leader();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_cycle(1, 1);
        send_cycle(2, 2);
        send_byte(8'h55);
        hold(70);
        check("t3_err", 32'(err), 32'd1);
        check("t3_wr_cnt", 32'(wr_count - wr_base), 32'd1);
        check("t3_addr", 32'(log_addr[wr_base]), 32'd0);
        check("t3_data", 32'(log_data[wr_base]), 32'h55);
        check("t3_length", 32'(length), 32'd1);

        // Framing error on first stop bit, then 12
        wr_base = wr_count;
        arm_capture();
        check("t4_err_cleared", 32'(err), 32'd0);
        leader();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(1'b0);
        check("t4_no_wr", 32'(wr_count - wr_base), 32'd0);
        check("t4_err", 32'(err), 32'd1);
        send_byte(8'h12);
        hold(70);
        check("t4_wr_cnt", 32'(wr_count - wr_base), 32'd1);
        check("t4_addr", 32'(log_addr[wr_base]), 32'd0);
        check("t4_data", 32'(log_data[wr_base]), 32'h12);

        // Reset mid-DATA of second byte
        wr_base = wr_count;
        arm_capture();
        leader();
        send_byte(8'h11);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t5_length_pre", 32'(length), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_wr", 32'(wr), 32'd0);
        check("t5_addr", 32'(addr), 32'd0);
        check("t5_data", 32'(data), 32'd0);
        check("t5_length", 32'(length), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        check("t5_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        wr_base = wr_count; done_base = done_count;
        leader();
        send_byte(8'h22);
        hold(70);
        check("t5_ignored_wr", 32'(wr_count - wr_base), 32'd0);
        check("t5_ignored_done", 32'(done_count - done_base), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);

        // Checksum over F0, 20
        wr_base = wr_count;
        arm_capture();
        leader();
        send_byte(8'hF0);
        send_byte(8'h20);
        hold(70);
        check("t6_wr_cnt", 32'(wr_count - wr_base), 32'd2);
        check("t6_data1", 32'(log_data[wr_base + 1]), 32'h20);
`ifdef TAPE_REC_CHECKSUM_EN
        exp_ck = 8'h10;
`else
        exp_ck = 8'h00;
`endif
        check("t6_checksum", 32'(checksum), 32'(exp_ck));
        check("wr_not_consecutive", 32'(consec_wr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
